// File: rtl/ringbuffer_drain.sv
// Read side of the capture ring buffer: fetches one record from the synchronous
// capture RAM and streams it as a framed byte sequence (header + MSB-first data).
module ringbuffer_drain #(
    parameter int DATA_WIDTH = 48
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  empty,
    input  logic                  overflow,
    output logic                  ram_rd_en,
    input  logic [DATA_WIDTH-1:0] ram_data,
    output logic                  read_done,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  busy
);

    localparam int NBYTES = DATA_WIDTH / 8;
    localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LATCH,
        HEADER,
        DATA,
        DONE
    } state_t;

    state_t                state_q, state_d;
    logic                  ovf_q, ovf_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    logic                  ram_rd_en_q, ram_rd_en_d;
    logic                  read_done_q, read_done_d;
    logic                  tx_valid_q, tx_valid_d;
    logic [7:0]            tx_data_q, tx_data_d;
    logic                  busy_q, busy_d;

    always_comb begin
        state_d = state_q;
        ovf_d   = ovf_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                if (!empty) state_d = FETCH;
            end
            FETCH: begin
                ovf_d   = overflow;
                state_d = LATCH;
            end
            LATCH: begin
                shreg_d = ram_data;
                cnt_d   = CNT_W'(NBYTES - 1);
                state_d = HEADER;
            end
            HEADER: begin
                if (tx_valid_q && tx_ready) state_d = DATA;
            end
            DATA: begin
                if (tx_valid_q && tx_ready) begin
                    shreg_d = shreg_q << 8;
                    if (cnt_q == '0) begin
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            DONE: begin
                // Always pass through IDLE so empty reflects the advanced pointer.
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered, so they are decoded from the next state.
        ram_rd_en_d = (state_d == FETCH);
        read_done_d = (state_d == DONE);
        tx_valid_d  = (state_d == HEADER) || (state_d == DATA);
        busy_d      = (state_d != IDLE);
        tx_data_d   = 8'h00;
        if (state_d == HEADER) begin
            tx_data_d = {7'b1010_000, ovf_d};
        end else if (state_d == DATA) begin
            tx_data_d = shreg_d[DATA_WIDTH-1 -: 8];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            ovf_q       <= 1'b0;
            shreg_q     <= '0;
            cnt_q       <= '0;
            ram_rd_en_q <= 1'b0;
            read_done_q <= 1'b0;
            tx_valid_q  <= 1'b0;
            tx_data_q   <= 8'h00;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ovf_q       <= ovf_d;
            shreg_q     <= shreg_d;
            cnt_q       <= cnt_d;
            ram_rd_en_q <= ram_rd_en_d;
            read_done_q <= read_done_d;
            tx_valid_q  <= tx_valid_d;
            tx_data_q   <= tx_data_d;
            busy_q      <= busy_d;
        end
    end

    assign ram_rd_en = ram_rd_en_q;
    assign read_done = read_done_q;
    assign tx_valid  = tx_valid_q;
    assign tx_data   = tx_data_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_ringbuffer_drain.sv
// Scoreboard bench for ringbuffer_drain: RAM/ring-buffer model, randomized
// handshake and overflow, expected frames queued at fetch time.
module tb_ringbuffer_drain;

    localparam int DW     = 48;
    localparam int NBYTES = DW / 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          empty;
    logic          overflow = 1'b0;
    logic          ram_rd_en;
    logic [DW-1:0] ram_data = '0;
    logic          read_done;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready = 1'b0;
    logic          busy;

    ringbuffer_drain #(.DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .empty     (empty),
        .overflow  (overflow),
        .ram_rd_en (ram_rd_en),
        .ram_data  (ram_data),
        .read_done (read_done),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Ring buffer model: records written at wr_ptr, consumed at rd_ptr.
    logic [DW-1:0] mem [0:255];
    int            wr_ptr = 0;
    int            rd_ptr = 0;
    assign empty = (rd_ptr == wr_ptr);

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] exp_q [$];
    int         cyc = 0;
    int         fetch_cyc = -100;
    int         done_cyc = -100;
    int         last_xfer_cyc = -100;
    int         frame_bytes = 0;
    int         done_cnt = 0;
    bit         done_seen = 0;
    bit         last_fetch_ok = 0;
    bit         stall_prev = 0;
    logic [7:0] stall_data = 8'h00;
    bit         valid_prev = 0;
    logic [7:0] last_hdr = 8'h00;

    int  ready_mode = 0;   // 0: always ready, 1: pattern 1,0,0, 2: random
    int  ovf_mode = 0;     // 0: ovf_val, 1: random
    bit  ovf_val = 0;
    bit  full_rate = 0;
    int  pat_i = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    // Synchronous capture RAM: data appears the cycle after ram_rd_en,
    // otherwise it carries junk so a mistimed capture is visible.
    initial forever begin
        @(posedge clk);
        if (ram_rd_en) ram_data <= mem[rd_ptr[7:0]];
        else           ram_data <= {$urandom, $urandom};
    end

    // Handshake and overflow drivers.
    initial forever begin
        @(posedge clk);
        #1;
        case (ready_mode)
            0: tx_ready = 1'b1;
            1: begin
                tx_ready = (pat_i == 0);
                pat_i = (pat_i + 1) % 3;
            end
            default: tx_ready = 1'($urandom_range(0, 1));
        endcase
        overflow = (ovf_mode == 1) ? 1'($urandom_range(0, 1)) : ovf_val;
    end

    // Monitor / scoreboard.
    initial forever begin
        @(negedge clk);
        cyc++;
        if (!reset) begin
            exp_q.delete();
            frame_bytes = 0;
            stall_prev = 0;
            valid_prev = 0;
            last_fetch_ok = 0;
        end else begin
            if (!tx_valid) chk("txdata_idle_zero", int'(tx_data), 0);
            if (ram_rd_en || read_done || tx_valid) chk("busy_active", int'(busy), 1);
            if (ram_rd_en) chk("rden_done_exclusive", int'({ram_rd_en, read_done}), 2);
            if (stall_prev) begin
                chk("stall_valid_held", int'(tx_valid), 1);
                chk("stall_data_held", int'(tx_data), int'(stall_data));
            end
            if (tx_valid && !valid_prev) chk("header_latency", cyc - fetch_cyc, 2);
            if (tx_valid && tx_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_byte", int'(tx_data), -1);
                end else begin
                    chk("frame_byte", int'(tx_data), int'(exp_q.pop_front()));
                end
                if (frame_bytes == 0) last_hdr = tx_data;
                frame_bytes++;
                last_xfer_cyc = cyc;
            end
            if (ram_rd_en) begin
                logic [DW-1:0] rec;
                if (done_seen) chk("done_to_fetch_gap_ge2", int'((cyc - done_cyc) >= 2), 1);
                if (full_rate && last_fetch_ok) chk("record_period", cyc - fetch_cyc, NBYTES + 5);
                chk("fetch_not_empty", int'(rd_ptr != wr_ptr), 1);
                rec = mem[rd_ptr[7:0]];
                exp_q.push_back({7'b1010_000, overflow});
                for (int i = NBYTES - 1; i >= 0; i--) exp_q.push_back(rec[i*8 +: 8]);
                fetch_cyc = cyc;
                last_fetch_ok = full_rate;
                frame_bytes = 0;
            end
            if (read_done) begin
                chk("frame_length", frame_bytes, NBYTES + 1);
                chk("done_after_last_byte", cyc - last_xfer_cyc, 1);
                rd_ptr++;
                done_cnt++;
                done_cyc = cyc;
                done_seen = 1;
            end
            if (!full_rate) last_fetch_ok = 0;
            stall_prev = tx_valid && !tx_ready;
            stall_data = tx_data;
            valid_prev = tx_valid;
        end
    end

    task automatic push_rec(input logic [DW-1:0] d);
        mem[wr_ptr[7:0]] = d;
        wr_ptr++;
    endtask

    task automatic drain(input string nm);
        bit ok;
        ok = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            #2;
            if (rd_ptr == wr_ptr && !busy && exp_q.size() == 0) begin
                ok = 1;
                break;
            end
        end
        chk(nm, int'(ok), 1);
    endtask

    initial begin
        int d0;
        int snap;
        bit seen;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rd_en", int'(ram_rd_en), 0);
        chk("rst_read_done", int'(read_done), 0);
        chk("rst_tx_valid", int'(tx_valid), 0);
        chk("rst_tx_data", int'(tx_data), 0);
        chk("rst_busy", int'(busy), 0);
        @(posedge clk);
        #1 reset = 1'b1;

        // Empty: nothing must happen.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("empty_idle", int'({ram_rd_en, tx_valid, read_done, busy}), 0);
        end

        // Full-rate transfers of the reference record, twice back to back.
        ready_mode = 0; ovf_val = 0; full_rate = 1;
        push_rec(48'h0123456789AB);
        push_rec(48'h0123456789AB);
        drain("drain_fullrate");
        full_rate = 0;

        // Stalled handshake with pattern 1,0,0.
        ready_mode = 1;
        d0 = done_cnt;
        push_rec(48'h0123456789AB);
        drain("drain_stalled");
        chk("stalled_one_done", done_cnt - d0, 1);

        // Overflow captured at fetch only.
        ready_mode = 0; ovf_val = 1;
        push_rec(48'hFEDCBA987654);
        seen = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (ram_rd_en) begin seen = 1; break; end
        end
        chk("ovf_fetch_seen", int'(seen), 1);
        repeat (3) @(posedge clk);
        #2 ovf_val = 0;
        drain("drain_ovf1");
        chk("header_ovf_set", int'(last_hdr), 8'hA1);
        push_rec(48'h00FF00FF00FF);
        drain("drain_ovf0");
        chk("header_ovf_clear", int'(last_hdr), 8'hA0);

        // Three back-to-back records.
        full_rate = 1;
        d0 = done_cnt;
        push_rec(48'h111111111111);
        push_rec(48'h222222222222);
        push_rec(48'h333333333333);
        drain("drain_three");
        chk("three_dones", done_cnt - d0, 3);
        full_rate = 0;

        // Reset during the third data byte.
        push_rec(48'hA5A5C3C35A5A);
        seen = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            #2;
            if (frame_bytes == 3 && tx_valid) begin seen = 1; break; end
        end
        chk("abort_point_reached", int'(seen), 1);
        snap = rd_ptr;
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("abort_outputs_zero", int'({ram_rd_en, read_done, tx_valid, busy, tx_data}), 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        chk("abort_no_read_done", rd_ptr, snap);
        drain("drain_after_abort");
        chk("header_after_abort", int'(last_hdr), 8'hA0);

        // Randomized traffic.
        ready_mode = 2; ovf_mode = 1;
        for (int r = 0; r < 10; r++) begin
            push_rec({$urandom, $urandom});
            repeat ($urandom_range(0, 15)) @(posedge clk);
        end
        drain("drain_random");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
